// File: rtl/wwd_seg_display_pkg.sv
// Shared constants for the 4-digit hex 7-segment display driver.
// Glyph encodings are {g,f,e,d,c,b,a} with a 0 lighting the segment.
package wwd_seg_display_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/wwd_seg_display_hex_to_seg.sv
// Combinational nibble-to-glyph decoder for a common-anode 7-segment digit.
module hex_to_seg
  import wwd_seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Map each hex value to its active-low segment pattern.
  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/wwd_seg_display.sv
// Samples the CPU output word, optionally freezes it, and multiplexes it as
// four hex digits onto a common-anode display. The shown value only changes
// at frame boundaries, and the decimal points flash for a few frames after a
// change. The PC byte is mirrored onto the LEDs.
module wwd_seg_display
  import wwd_seg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic [7:0]  pc_in,
  input  logic        freeze,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic [7:0]  led
);

  logic [15:0] count_reg;
  logic [1:0]  digit_reg;
  logic        freeze_meta_reg;
  logic        freeze_s_reg;
  logic [15:0] captured_reg;
  logic [15:0] shown_reg;
  logic [15:0] prev_reg;
  logic [7:0]  flash_reg;

  logic        tick;
  logic        frame_end;
  logic [1:0]  digit_next;
  logic [15:0] shown_next;
  logic [7:0]  flash_next;
  logic [3:0]  an_next;
  logic [3:0]  nibble_sel;
  logic [6:0]  seg_dec;

  // Slot timing, frame boundary and change-flash bookkeeping.
  always_comb begin
    tick       = (count_reg == 16'(SCAN_DIV - 1));
    digit_next = tick ? digit_reg + 2'd1 : digit_reg;
    frame_end  = tick && (digit_reg == 2'd3);
    shown_next = frame_end ? captured_reg : shown_reg;
    flash_next = flash_reg;
    if (frame_end) begin
      if (captured_reg != prev_reg) begin
        flash_next = 8'(FLASH_FRAMES);
      end else if (flash_reg != 8'd0) begin
        flash_next = flash_reg - 8'd1;
      end
    end
    // Look ahead to the value and digit that will be live after this edge so
    // the registered segments always match the registered anode.
    nibble_sel = shown_next[{digit_next, 2'b00} +: 4];
  end

  // One anode enable per digit, low only for the selected one.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
    assign an_next[gi] = (digit_next != 2'(gi));
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_sel),
    .seg_n  (seg_dec)
  );

  // Two-flop synchronizer for the freeze switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeze_meta_reg <= 1'b0;
      freeze_s_reg    <= 1'b0;
    end else begin
      freeze_meta_reg <= freeze;
      freeze_s_reg    <= freeze_meta_reg;
    end
  end

  // Track the CPU word while not frozen; mirror the PC byte onto the LEDs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      captured_reg <= 16'h0000;
      led          <= 8'h00;
    end else begin
      if (!freeze_s_reg) begin
        captured_reg <= data_in;
      end
      led <= pc_in;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 16'h0000;
      digit_reg <= 2'd0;
    end else begin
      count_reg <= tick ? 16'h0000 : count_reg + 16'd1;
      digit_reg <= digit_next;
    end
  end

  // Frame-boundary latch of the displayed value and change history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shown_reg <= 16'h0000;
      prev_reg  <= 16'h0000;
      flash_reg <= 8'd0;
    end else begin
      shown_reg <= shown_next;
      flash_reg <= flash_next;
      if (frame_end) begin
        prev_reg <= captured_reg;
      end
    end
  end

  // Display pins change together with the digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_n  <= 4'b1110;
      seg_n <= SEG_0;
      dp_n  <= 1'b1;
    end else if (tick) begin
      an_n  <= an_next;
      seg_n <= seg_dec;
      dp_n  <= (flash_next == 8'd0);
    end
  end

endmodule

// File: tb/tb_wwd_seg_display.sv
// Scoreboard bench for wwd_seg_display with a short scan period.
module tb_wwd_seg_display;

  localparam int SCAN_DIV     = 4;
  localparam int FLASH_FRAMES = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [7:0]  pc_in;
  logic        freeze;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [7:0]  led;

  int    errors = 0;
  int    checks = 0;
  slot_t sb_q[$];

  wwd_seg_display #(
    .SCAN_DIV     (SCAN_DIV),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .pc_in   (pc_in),
    .freeze  (freeze),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Wait (at negedges) until an_n changes; reports clocks spent.
  task automatic wait_an_change(output int clks, output bit ok);
    logic [3:0] last_an;
    last_an = an_n;
    ok = 1'b0;
    clks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      clks++;
      if (an_n !== last_an) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Queue the expected four slots of one frame.
  task automatic push_frame(input logic [15:0] v, input logic dp);
    slot_t e;
    logic [3:0] nib;
    for (int d = 0; d < 4; d++) begin
      nib   = v[d*4 +: 4];
      e.an  = ~(4'b0001 << d);
      e.seg = GLYPH[nib];
      e.dp  = dp;
      sb_q.push_back(e);
    end
  endtask

  // Pop one expected slot and compare against the live outputs.
  task automatic check_slot(input string name);
    slot_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got an_n=%b seg_n=%b dp_n=%b", name, an_n, seg_n, dp_n);
    end else begin
      e = sb_q.pop_front();
      if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp) begin
        errors++;
        $display("FAIL %s: got an_n=%b seg_n=%b dp_n=%b expected an_n=%b seg_n=%b dp_n=%b",
                 name, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
      end else begin
        $display("ok   %s: an_n=%b seg_n=%b dp_n=%b", name, an_n, seg_n, dp_n);
      end
    end
  endtask

  task automatic check_dwell(input string name, input int clks, input bit ok);
    checks++;
    if (!ok || clks != SCAN_DIV) begin
      errors++;
      $display("FAIL %s dwell: got %0d clocks (moved=%0b) expected %0d", name, clks, ok, SCAN_DIV);
    end
  endtask

  // Starting at slot 0 of a frame: check the whole frame, driving data_in
  // and freeze at the chosen slot, then advance to slot 0 of the next frame.
  task automatic frame_step(input string name, input logic [15:0] drive, input int drive_slot,
                            input logic frz, input logic [15:0] ev, input logic edp);
    int clks;
    bit ok;
    push_frame(ev, edp);
    freeze = frz;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        wait_an_change(clks, ok);
        check_dwell(name, clks, ok);
      end
      if (s == drive_slot) data_in = drive;
      check_slot($sformatf("%s d%0d", name, s));
    end
    wait_an_change(clks, ok);
    check_dwell(name, clks, ok);
  endtask

  task automatic sync_frame_start();
    int clks;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      wait_an_change(clks, ok);
      if (ok && an_n == 4'b1110) return;
    end
    errors++;
    checks++;
    $display("FAIL sync: never reached digit 0, an_n=%b", an_n);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    data_in = 16'h0000;
    pc_in   = 8'h00;
    freeze  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1000000 || dp_n !== 1'b1 || led !== 8'h00) begin
      errors++;
      $display("FAIL reset: got an_n=%b seg_n=%b dp_n=%b led=%h", an_n, seg_n, dp_n, led);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== 4'b1110) begin
        errors++;
        $display("FAIL reset clk%0d: got an_n=%b expected 1110", i, an_n);
      end
    end
    @(negedge clk);
    checks++;
    if (an_n !== 4'b1101 || seg_n !== 7'b1000000 || dp_n !== 1'b1) begin
      errors++;
      $display("FAIL first tick: got an_n=%b seg_n=%b dp_n=%b expected 1101 1000000 1", an_n, seg_n, dp_n);
    end
  endtask

  task automatic test_led();
    pc_in = 8'hA5;
    @(negedge clk);
    checks++;
    if (led !== 8'hA5) begin
      errors++;
      $display("FAIL led: got %h expected a5", led);
    end
  endtask

  task automatic test_scan_and_flash();
    frame_step("scan0",  16'h5678, 0, 1'b0, 16'h0000, 1'b1);
    frame_step("scan1",  16'h5678, 0, 1'b0, 16'h5678, 1'b0);
    frame_step("scan2",  16'h5678, 0, 1'b0, 16'h5678, 1'b0);
    frame_step("scan3",  16'h0000, 0, 1'b0, 16'h5678, 1'b1);
    frame_step("zero1",  16'h0000, 0, 1'b0, 16'h0000, 1'b0);
    frame_step("zero2",  16'h0000, 0, 1'b0, 16'h0000, 1'b0);
    frame_step("zero3",  16'hF000, 0, 1'b0, 16'h0000, 1'b1);
    frame_step("flashA", 16'h0F00, 0, 1'b0, 16'hF000, 1'b0);
    frame_step("reload1", 16'h0F00, 0, 1'b0, 16'h0F00, 1'b0);
    frame_step("reload2", 16'h0F00, 0, 1'b0, 16'h0F00, 1'b0);
    frame_step("reload3", 16'h00FF, 0, 1'b0, 16'h0F00, 1'b1);
  endtask

  task automatic test_freeze();
    frame_step("frz0", 16'h00FF, 0, 1'b1, 16'h00FF, 1'b0);
    frame_step("frz1", 16'hFFFF, 0, 1'b1, 16'h00FF, 1'b0);
    frame_step("frz2", 16'hFFFF, 0, 1'b1, 16'h00FF, 1'b1);
    frame_step("frz3", 16'hFFFF, 0, 1'b0, 16'h00FF, 1'b1);
    frame_step("unfrz", 16'h1234, 0, 1'b0, 16'hFFFF, 1'b0);
  endtask

  task automatic test_mid_frame();
    frame_step("mid0", 16'hABCD, 1, 1'b0, 16'h1234, 1'b0);
    frame_step("mid1", 16'hABCD, 0, 1'b0, 16'hABCD, 1'b0);
    frame_step("mid2", 16'hABCD, 0, 1'b0, 16'hABCD, 1'b0);
  endtask

  task automatic test_async_reset();
    int clks;
    bit ok;
    pc_in = 8'h5A;
    wait_an_change(clks, ok);
    wait_an_change(clks, ok);
    checks++;
    if (an_n !== 4'b1011 || led !== 8'h5A) begin
      errors++;
      $display("FAIL pre-reset: got an_n=%b led=%h expected 1011 5a", an_n, led);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1000000 || dp_n !== 1'b1 || led !== 8'h00) begin
      errors++;
      $display("FAIL async reset: got an_n=%b seg_n=%b dp_n=%b led=%h", an_n, seg_n, dp_n, led);
    end
    pc_in = 8'h2C;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL led at release: got %h expected 00", led);
    end
    @(negedge clk);
    checks++;
    if (led !== 8'h2C || an_n !== 4'b1110) begin
      errors++;
      $display("FAIL led after release: got led=%h an_n=%b expected 2c 1110", led, an_n);
    end
    wait_an_change(clks, ok);
    checks++;
    if (!ok || clks != SCAN_DIV - 1 || an_n !== 4'b1101) begin
      errors++;
      $display("FAIL restart slot: got %0d more clocks an_n=%b expected %0d 1101", clks, an_n, SCAN_DIV - 1);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    sync_frame_start();
    test_scan_and_flash();
    test_freeze();
    test_mid_frame();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
